// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access path: access-size codes,
// controller states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // The reserved size code is treated as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication and byte enables,
// load byte/half extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lanes: replicate the right-justified data across the word.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load lanes: pick the addressed byte/half and extend it.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: rdata_o = {{24{sign_ext_i & byte_s[7]}}, byte_s};
            SZ_HALF: rdata_o = {{16{sign_ext_i & half_s[15]}}, half_s};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage access controller: turns EX/MEM load/store controls into a
// request/grant/rvalid bus transaction and stalls the pipeline meanwhile.
module mem_stage_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic [1:0]  size_m,
    input  logic        sign_ext_m,
    output logic        stall_m,
    output logic [31:0] rdata_m,
    output logic        done_m,
    output logic        addr_err,
    output logic [31:0] bad_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    state_e      state_q;
    logic        bus_req_q, bus_we_q, done_q, addr_err_q;
    logic [31:0] bus_addr_q, bus_wdata_q, rdata_q, bad_addr_q;
    logic [3:0]  bus_be_q;

    logic        want_s, aligned_s, access_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, ext_s;

    assign want_s    = mem_read_m | mem_write_m;
    assign aligned_s = is_aligned(size_m, addr_m[1:0]);
    assign access_s  = want_s & aligned_s;
    // Low in DONE so the pipeline advances exactly once per access.
    assign stall_m   = access_s & (state_q != ST_DONE);

    mem_lane_align u_align (
        .addr_lo_i  (addr_m[1:0]),
        .size_i     (size_m),
        .sign_ext_i (sign_ext_m),
        .wdata_i    (wdata_m),
        .rdata_i    (bus_rdata),
        .be_o       (be_s),
        .wdata_o    (wdata_s),
        .rdata_o    (ext_s)
    );

    // Access FSM with registered bus and pipeline-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            bad_addr_q  <= 32'd0;
        end else begin
            addr_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (access_s) begin
                        state_q     <= ST_REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_write_m;
                        bus_addr_q  <= {addr_m[31:2], 2'b00};
                        bus_be_q    <= mem_write_m ? be_s : 4'b1111;
                        bus_wdata_q <= mem_write_m ? wdata_s : 32'd0;
                    end else if (want_s) begin
                        addr_err_q <= 1'b1;
                        bad_addr_q <= addr_m;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        if (bus_we_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (bus_rvalid) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            rdata_q <= ext_s;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        rdata_q <= ext_s;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bus_req_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata_m   = rdata_q;
    assign done_m    = done_q;
    assign addr_err  = addr_err_q;
    assign bad_addr  = bad_addr_q;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller for the five-stage MIPS pipeline. It sits after the EX/MEM pipeline register and consumes that register's M-stage outputs: ALU result as address, store data, and read/write controls. It drives a word-wide request/grant/read-valid data bus, stalls the pipeline while an access is outstanding, and returns aligned, sign- or zero-extended load data to the MEM/WB register.

## Interface
Parameters:
- none (bus width fixed at 32, address width fixed at 32)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_read_m  in  1  load in M stage (MemtoReg_M)
- mem_write_m  in  1  store in M stage (MemWrite_M)
- addr_m  in  32  byte address (ALUOut_M)
- wdata_m  in  32  store data (WriteData_M), right-justified
- size_m  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- sign_ext_m  in  1  sign-extend load result (lb/lh), else zero-extend
- stall_m  out  1  hold F/D/E/M stages this cycle
- rdata_m  out  32  extracted load data, valid while done_m=1
- done_m  out  1  access completes this cycle; pipeline advances
- addr_err  out  1  one-cycle pulse: misaligned access rejected
- bad_addr  out  32  faulting address, held until next addr_err
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr_m[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data word

## Operation
- access = (mem_read_m | mem_write_m) & aligned. Aligned: byte always; half addr_m[0]=0; word addr_m[1:0]=0. If both read and write are asserted, the write takes precedence.
- Misaligned: no bus activity, stall_m=0, addr_err=1 for exactly one cycle (in IDLE), bad_addr<=addr_m.
- FSM states IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ when access.
  - REQ: bus_req=1 and outputs held stable until bus_gnt. Write goes to DONE on gnt. Read goes to WAIT on gnt, or directly to DONE if bus_rvalid is in the same cycle as gnt.
  - WAIT -> DONE on bus_rvalid; rdata_m is registered from bus_rdata at that edge.
  - DONE -> IDLE unconditionally.
- stall_m = access & (state != DONE), combinational. It is 0 in DONE, so the pipeline advances exactly once per access.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata_m[7:0]}}
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata_m[15:0]}}
  - word: be = 4'b1111
- Load extract: select the byte at addr[1:0] or the half at addr[1], then sign- or zero-extend to 32 bits per sign_ext_m. Word loads pass through unchanged.
- bus_be = 4'b1111 on reads.

## Timing
- Reset values: state IDLE; stall_m follows inputs (0 when no access); bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, rdata_m 0, done_m 0, addr_err 0, bad_addr 0.
- Bus outputs are registered. Minimum latency with gnt in the first REQ cycle:
  - write: 3 cycles (IDLE, REQ, DONE)
  - read: 3 cycles if rvalid arrives with gnt, else 4 or more
- Stall cycles per access: write 2 minimum; read 2 minimum.
- bus_rvalid outside WAIT, or outside REQ-with-gnt, is ignored.
- Reset mid-access: returns to IDLE next edge, drops bus_req, discards any late rvalid.

## Structure
- Shared package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the state enum.
- One sub-module, mem_lane_align: combinational store lane replication/byte enables and load extraction, reused by the future cache path.

## Test plan
- Aligned sw addr 0x0000_1004, data 0xDEAD_BEEF, gnt on first REQ cycle -> bus_be 4'b1111, bus_addr 0x1004, stall_m high 2 cycles, done_m 1 cycle.
- sb addr 0x0000_2003, data 0x0000_00A5 -> be 4'b1000, bus_wdata 0xA5A5_A5A5.
- lb addr 0x0000_3001 with sign_ext=1, bus_rdata 0x1234_80FF, rvalid 3 cycles after gnt -> rdata_m 0xFFFF_FF80, stall_m held through WAIT.
- lhu addr 0x0000_4002, bus_rdata 0x8001_7777 -> rdata_m 0x0000_8001.
- lw addr 0x0000_5002 -> addr_err single pulse, bad_addr 0x0000_5002, bus_req never asserted, stall_m 0.
- Reset asserted in WAIT, then rvalid next cycle -> state IDLE, done_m 0, rdata_m 0.
